// File: rtl/gen_dir_burst.sv
// Registered, handshaked 8086-style physical address generator.
// One accepted request emits a burst of len_i+1 sequential addresses.
module gen_dir_burst #(
    parameter int unsigned OffW     = 16,
    parameter int unsigned SegShift = 4,
    parameter int unsigned BurstW   = 2,
    localparam int unsigned AddrW   = OffW + SegShift
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              op_i,
    input  logic [1:0]        seg_sel_i,
    input  logic [2:0]        m1_sel_i,
    input  logic [2:0]        m2_sel_i,
    input  logic [OffW-1:0]   bx_i,
    input  logic [OffW-1:0]   si_i,
    input  logic [OffW-1:0]   di_i,
    input  logic [OffW-1:0]   bp_i,
    input  logic [OffW-1:0]   sp_i,
    input  logic [OffW-1:0]   cs_i,
    input  logic [OffW-1:0]   ds_i,
    input  logic [OffW-1:0]   es_i,
    input  logic [OffW-1:0]   ss_i,
    input  logic [OffW-1:0]   ip_i,
    input  logic [OffW-1:0]   desp_i,
    input  logic [BurstW-1:0] len_i,
    input  logic              size_i,
    output logic              dir_valid_o,
    input  logic              dir_ready_i,
    output logic [AddrW-1:0]  dir_o,
    output logic [OffW-1:0]   dir_off_o,
    output logic              dir_last_o,
    output logic              busy_o
);

    typedef enum logic {StIdle, StEmit} state_e;

    state_e              state_q;
    logic                req_ready_q;
    logic                dir_valid_q;
    logic [AddrW-1:0]    dir_q;
    logic [OffW-1:0]     dir_off_q;
    logic                dir_last_q;
    logic                busy_q;
    logic [OffW-1:0]     seg_q;
    logic [BurstW-1:0]   cnt_q;
    logic                step_q;

    logic [OffW-1:0]     m1_val;
    logic [OffW-1:0]     m2_val;
    logic [OffW-1:0]     data_seg;
    logic [OffW-1:0]     acc_seg;
    logic [OffW-1:0]     acc_off;
    logic [OffW-1:0]     off_next;

    // Both terms are widened to AddrW so the sum wraps at the top of memory.
    function automatic logic [AddrW-1:0] phys(input logic [OffW-1:0] seg,
                                              input logic [OffW-1:0] off);
        return {seg, {SegShift{1'b0}}} + {{SegShift{1'b0}}, off};
    endfunction

    always_comb begin
        m1_val = '0;
        case (m1_sel_i)
            3'b000:  m1_val = bx_i;
            3'b001:  m1_val = si_i;
            3'b010:  m1_val = di_i;
            3'b011:  m1_val = bp_i;
            3'b100:  m1_val = sp_i;
            default: m1_val = '0;
        endcase

        m2_val = '0;
        case (m2_sel_i)
            3'b000:  m2_val = bx_i;
            3'b001:  m2_val = si_i;
            3'b010:  m2_val = di_i;
            3'b011:  m2_val = bp_i;
            3'b100:  m2_val = sp_i;
            default: m2_val = '0;
        endcase

        data_seg = cs_i;
        case (seg_sel_i)
            2'b00:   data_seg = cs_i;
            2'b01:   data_seg = ds_i;
            2'b10:   data_seg = es_i;
            default: data_seg = ss_i;
        endcase

        acc_seg  = op_i ? data_seg : cs_i;
        acc_off  = op_i ? (m1_val + m2_val + desp_i) : ip_i;
        off_next = dir_off_q + (step_q ? OffW'(2) : OffW'(1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b0;
            dir_valid_q <= 1'b0;
            dir_q       <= '0;
            dir_off_q   <= '0;
            dir_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            seg_q       <= '0;
            cnt_q       <= '0;
            step_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (req_valid_i && req_ready_q) begin
                        seg_q       <= acc_seg;
                        dir_off_q   <= acc_off;
                        dir_q       <= phys(acc_seg, acc_off);
                        cnt_q       <= len_i;
                        step_q      <= size_i;
                        dir_last_q  <= (len_i == '0);
                        dir_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        req_ready_q <= 1'b0;
                        state_q     <= StEmit;
                    end
                end
                StEmit: begin
                    if (dir_ready_i) begin
                        if (cnt_q == '0) begin
                            state_q     <= StIdle;
                            dir_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            dir_last_q  <= 1'b0;
                            req_ready_q <= 1'b1;
                        end else begin
                            // Offset wraps inside the segment; segment base stays fixed.
                            dir_off_q  <= off_next;
                            dir_q      <= phys(seg_q, off_next);
                            cnt_q      <= cnt_q - BurstW'(1);
                            dir_last_q <= (cnt_q == BurstW'(1));
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign dir_valid_o = dir_valid_q;
    assign dir_o       = dir_q;
    assign dir_off_o   = dir_off_q;
    assign dir_last_o  = dir_last_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_gen_dir_burst.sv
// Directed bench for gen_dir_burst: single-beat vector table plus hand-written
// burst, backpressure, reset and back-to-back sequences.
module tb_gen_dir_burst;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        op;
    logic [1:0]  seg_sel;
    logic [2:0]  m1_sel;
    logic [2:0]  m2_sel;
    logic [15:0] bx, si, di, bp, sp, cs, ds, es, ss, ip, desp;
    logic [1:0]  len;
    logic        size;
    logic        dir_valid;
    logic        dir_ready;
    logic [19:0] dir;
    logic [15:0] dir_off;
    logic        dir_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gen_dir_burst dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .op_i        (op),
        .seg_sel_i   (seg_sel),
        .m1_sel_i    (m1_sel),
        .m2_sel_i    (m2_sel),
        .bx_i        (bx),
        .si_i        (si),
        .di_i        (di),
        .bp_i        (bp),
        .sp_i        (sp),
        .cs_i        (cs),
        .ds_i        (ds),
        .es_i        (es),
        .ss_i        (ss),
        .ip_i        (ip),
        .desp_i      (desp),
        .len_i       (len),
        .size_i      (size),
        .dir_valid_o (dir_valid),
        .dir_ready_i (dir_ready),
        .dir_o       (dir),
        .dir_off_o   (dir_off),
        .dir_last_o  (dir_last),
        .busy_o      (busy)
    );

    typedef struct {
        logic        op;
        logic [1:0]  seg_sel;
        logic [2:0]  m1;
        logic [2:0]  m2;
        logic [15:0] desp;
        logic [19:0] exp_dir;
        logic [15:0] exp_off;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string name, input logic [19:0] e_dir,
                              input logic [15:0] e_off, input logic e_last);
        check({name, ".valid"}, {31'd0, dir_valid}, 32'd1);
        check({name, ".busy"}, {31'd0, busy}, 32'd1);
        check({name, ".dir"}, {12'd0, dir}, {12'd0, e_dir});
        check({name, ".off"}, {16'd0, dir_off}, {16'd0, e_off});
        check({name, ".last"}, {31'd0, dir_last}, {31'd0, e_last});
    endtask

    // Waits (bounded) for req_ready, then presents one request for one cycle.
    task automatic send_req(input logic o, input logic [1:0] ss_sel, input logic [2:0] a,
                            input logic [2:0] b, input logic [15:0] d,
                            input logic [1:0] l, input logic sz);
        int n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        if (!req_ready) check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        op = o; seg_sel = ss_sel; m1_sel = a; m2_sel = b; desp = d; len = l; size = sz;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        logic [19:0] t2_dir[4];
        logic [15:0] t2_off[4];
        logic        pulses[6];

        rst = 1'b1; req_valid = 1'b0; dir_ready = 1'b0;
        op = 1'b0; seg_sel = 2'b00; m1_sel = 3'b000; m2_sel = 3'b000;
        bx = 16'h0010; si = 16'h0020; di = 16'h0300; bp = 16'h8000; sp = 16'hFFF0;
        cs = 16'hF000; ds = 16'h1234; es = 16'hFFFF; ss = 16'h0100; ip = 16'hFFFE;
        desp = 16'h0000; len = 2'd0; size = 1'b0;

        vecs[0] = '{1'b1, 2'b01, 3'b000, 3'b001, 16'h0005, 20'h12375, 16'h0035};
        vecs[1] = '{1'b1, 2'b10, 3'b000, 3'b111, 16'h0000, 20'h00000, 16'h0010};
        vecs[2] = '{1'b1, 2'b11, 3'b011, 3'b011, 16'h8000, 20'h09000, 16'h8000};
        vecs[3] = '{1'b0, 2'b01, 3'b001, 3'b010, 16'h1111, 20'hFFFFE, 16'hFFFE};
        vecs[4] = '{1'b1, 2'b00, 3'b010, 3'b100, 16'h0012, 20'hF0302, 16'h0302};
        vecs[5] = '{1'b1, 2'b10, 3'b101, 3'b110, 16'h1234, 20'h01224, 16'h1234};
        vecs[6] = '{1'b1, 2'b01, 3'b100, 3'b111, 16'h0010, 20'h12340, 16'h0000};

        t2_dir = '{20'hFFFFE, 20'hF0000, 20'hF0002, 20'hF0004};
        t2_off = '{16'hFFFE, 16'h0000, 16'h0002, 16'h0004};

        // Reset state
        step(); step();
        check("rst.valid", {31'd0, dir_valid}, 32'd0);
        check("rst.dir", {12'd0, dir}, 32'd0);
        check("rst.off", {16'd0, dir_off}, 32'd0);
        check("rst.last", {31'd0, dir_last}, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        step();
        check("post_rst.ready", {31'd0, req_ready}, 32'd1);

        // Single-beat table
        for (int i = 0; i < 7; i++) begin
            send_req(vecs[i].op, vecs[i].seg_sel, vecs[i].m1, vecs[i].m2, vecs[i].desp,
                     2'd0, 1'b0);
            check_beat($sformatf("vec%0d", i), vecs[i].exp_dir, vecs[i].exp_off, 1'b1);
            check($sformatf("vec%0d.ready_lo", i), {31'd0, req_ready}, 32'd0);
            dir_ready = 1'b1;
            step();
            dir_ready = 1'b0;
            check($sformatf("vec%0d.done_valid", i), {31'd0, dir_valid}, 32'd0);
            check($sformatf("vec%0d.done_ready", i), {31'd0, req_ready}, 32'd1);
        end

        // Instruction burst, word steps, offset wrap inside CS
        dir_ready = 1'b1;
        send_req(1'b0, 2'b00, 3'b000, 3'b000, 16'h0000, 2'd3, 1'b1);
        for (int b = 0; b < 4; b++) begin
            check_beat($sformatf("t2.beat%0d", b), t2_dir[b], t2_off[b], b == 3);
            step();
        end
        check("t2.end_valid", {31'd0, dir_valid}, 32'd0);
        check("t2.end_ready", {31'd0, req_ready}, 32'd1);

        // Backpressure on beat 2, with CS/IP changed mid-burst
        send_req(1'b0, 2'b00, 3'b000, 3'b000, 16'h0000, 2'd3, 1'b1);
        check_beat("t4.beat0", 20'hFFFFE, 16'hFFFE, 1'b0);
        step();
        dir_ready = 1'b0;
        cs = 16'h1234;
        ip = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            step();
            check_beat($sformatf("t4.hold%0d", k), 20'hF0000, 16'h0000, 1'b0);
            check($sformatf("t4.hold%0d.ready", k), {31'd0, req_ready}, 32'd0);
        end
        dir_ready = 1'b1;
        step();
        check_beat("t4.beat2", 20'hF0002, 16'h0002, 1'b0);
        step();
        check_beat("t4.beat3", 20'hF0004, 16'h0004, 1'b1);
        step();
        check("t4.end_valid", {31'd0, dir_valid}, 32'd0);
        cs = 16'hF000;
        ip = 16'hFFFE;

        // Reset mid-burst
        send_req(1'b0, 2'b00, 3'b000, 3'b000, 16'h0000, 2'd3, 1'b1);
        step();
        check_beat("t5.beat1", 20'hF0000, 16'h0000, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5.rst_valid", {31'd0, dir_valid}, 32'd0);
        check("t5.rst_busy", {31'd0, busy}, 32'd0);
        check("t5.rst_ready", {31'd0, req_ready}, 32'd0);
        step();
        check("t5.ready_after", {31'd0, req_ready}, 32'd1);
        check("t5.no_beat", {31'd0, dir_valid}, 32'd0);
        step();
        check("t5.no_beat2", {31'd0, dir_valid}, 32'd0);

        // Back-to-back single-beat requests: one idle cycle between pulses
        op = 1'b1; seg_sel = 2'b01; m1_sel = 3'b000; m2_sel = 3'b001; desp = 16'h0005;
        len = 2'd0; size = 1'b0;
        req_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            pulses[c] = dir_valid;
        end
        req_valid = 1'b0;
        for (int c = 0; c < 6; c++)
            check($sformatf("t6.pulse%0d", c), {31'd0, pulses[c]}, {31'd0, (c % 2) == 0});

        // Byte-step burst
        send_req(1'b1, 2'b01, 3'b000, 3'b111, 16'h0000, 2'd2, 1'b0);
        for (int b = 0; b < 3; b++) begin
            check_beat($sformatf("t6.byte%0d", b), 20'h12350 + 20'(b), 16'h0010 + 16'(b),
                       b == 2);
            step();
        end
        check("t6.byte_end", {31'd0, dir_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
